// File: rtl/axi_lite_reg_bank.sv
// AXI-Lite register bank: CTRL, SCRATCH, STATUS, COUNT registers
// fed by a write strobe, plus a two-state AXI-Lite read slave.
module axi_lite_reg_bank #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [DATA_WIDTH-1:0] status_in,
  output logic [DATA_WIDTH-1:0] ctrl_out
);

  localparam logic       R_IDLE = 1'b0;
  localparam logic       R_DATA = 1'b1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic                  r_state;
  logic [DATA_WIDTH-1:0] r_ctrl;
  logic [DATA_WIDTH-1:0] r_scratch;
  logic [DATA_WIDTH-1:0] r_status;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [1:0]            r_rresp;

  logic [1:0]            w_wr_idx;
  logic [1:0]            w_rd_idx;
  logic                  w_wr_oor;
  logic                  w_rd_oor;
  logic                  w_wr_ok;
  logic                  w_wr_ctrl;
  logic                  w_wr_scr;
  logic                  w_cnt_clr;
  logic [DATA_WIDTH-1:0] w_rd_val;
  logic                  w_unused;

  assign w_wr_idx = wr_addr[3:2];
  assign w_rd_idx = araddr[3:2];

  // Byte-lane bits are not decoded.
  assign w_unused = ^{wr_addr[1:0], araddr[1:0]};

  generate
    if (ADDR_WIDTH > 4) begin : g_hi
      assign w_wr_oor = |wr_addr[ADDR_WIDTH-1:4];
      assign w_rd_oor = |araddr[ADDR_WIDTH-1:4];
    end else begin : g_nohi
      assign w_wr_oor = 1'b0;
      assign w_rd_oor = 1'b0;
    end
  endgenerate

  assign w_wr_ok   = wr_en & ~w_wr_oor;
  assign w_wr_ctrl = w_wr_ok & (w_wr_idx == 2'd0);
  assign w_wr_scr  = w_wr_ok & (w_wr_idx == 2'd1);
  assign w_cnt_clr = w_wr_ctrl & wr_data[1];

  // Bit1 is a pulse that only acts on the counter; never stored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl <= '0;
    end else if (w_wr_ctrl) begin
      r_ctrl <= {wr_data[DATA_WIDTH-1:2], 1'b0, wr_data[0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scratch <= '0;
    end else if (w_wr_scr) begin
      r_scratch <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_status <= '0;
    end else begin
      r_status <= status_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_cnt_clr) begin
      r_count <= '0;
    end else if (r_ctrl[0]) begin
      r_count <= r_count + DATA_WIDTH'(1);
    end
  end

  always_comb begin
    w_rd_val = '0;
    unique case (w_rd_idx)
      2'd0: w_rd_val = r_ctrl;
      2'd1: w_rd_val = r_scratch;
      2'd2: w_rd_val = r_status;
      2'd3: w_rd_val = r_count;
      default: w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_rdata <= '0;
      r_rresp <= OKAY;
    end else begin
      unique case (r_state)
        R_IDLE: begin
          if (arvalid) begin
            r_rdata <= w_rd_oor ? '0 : w_rd_val;
            r_rresp <= w_rd_oor ? SLVERR : OKAY;
            r_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (rready) begin
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign arready  = ~rst & (r_state == R_IDLE);
  assign rvalid   = (r_state == R_DATA);
  assign rdata    = r_rdata;
  assign rresp    = r_rresp;
  assign ctrl_out = r_ctrl;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Scoreboard bench for axi_lite_reg_bank (ADDR_WIDTH=6 so that
// out-of-range decode is reachable).
module tb_axi_lite_reg_bank;

  typedef struct packed {
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic [5:0]  wr_addr;
  logic [31:0] wr_data;
  logic [5:0]  araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] status_in;
  logic [31:0] ctrl_out;

  int checks;
  int errors;
  exp_t q[$];

  logic [31:0] m_ctrl;
  logic [31:0] m_scr;
  logic [31:0] m_stat;
  logic [31:0] m_cnt;

  axi_lite_reg_bank #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .araddr(araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata(rdata),
    .rresp(rresp),
    .rvalid(rvalid),
    .rready(rready),
    .status_in(status_in),
    .ctrl_out(ctrl_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural register model, advanced on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_ctrl <= 0;
      m_scr  <= 0;
      m_stat <= 0;
      m_cnt  <= 0;
    end else begin
      m_stat <= status_in;
      if (wr_en && wr_addr[5:4] == 2'b00 && wr_addr[3:2] == 2'd0)
        m_ctrl <= wr_data & 32'hFFFF_FFFD;
      if (wr_en && wr_addr[5:4] == 2'b00 && wr_addr[3:2] == 2'd1)
        m_scr <= wr_data;
      if (wr_en && wr_addr[5:4] == 2'b00 && wr_addr[3:2] == 2'd0
          && wr_data[1])
        m_cnt <= 0;
      else if (m_ctrl[0])
        m_cnt <= m_cnt + 1;
    end
  end

  function automatic exp_t model_exp(input logic [5:0] a);
    exp_t e;
    e.r = 2'b00;
    e.d = 32'h0;
    if (a[5:4] != 2'b00) begin
      e.r = 2'b10;
    end else begin
      case (a[3:2])
        2'd0: e.d = m_ctrl;
        2'd1: e.d = m_scr;
        2'd2: e.d = m_stat;
        default: e.d = m_cnt;
      endcase
    end
    return e;
  endfunction

  task automatic do_write(input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_read(input logic [5:0] a, input string nm,
                         output logic [31:0] got);
    exp_t e;
    int n;
    got = 32'h0;
    @(negedge clk);
    araddr = a;
    arvalid = 1'b1;
    rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!arready) begin
      errors++;
      $display("FAIL %s ar_timeout arready=%b required 1", nm, arready);
      arvalid = 1'b0;
      return;
    end
    q.push_back(model_exp(a));
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL %s rvalid_latency got=%b required 1", nm, rvalid);
    end
    e = q.pop_front();
    got = rdata;
    checks++;
    if (rdata !== e.d || rresp !== e.r) begin
      errors++;
      $display("FAIL %s rdata=%h rresp=%b required %h/%b",
               nm, rdata, rresp, e.d, e.r);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (arready !== 1'b0 || rvalid !== 1'b0 || rdata !== 32'h0 ||
        rresp !== 2'b00 || ctrl_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_state ar=%b rv=%b rd=%h rr=%b ctrl=%h required 0",
               arready, rvalid, rdata, rresp, ctrl_out);
    end
    rst = 1'b0;
    do_read(6'h04, "reset_read_scratch", v);
    checks++;
    if (v !== 32'h0) begin
      errors++;
      $display("FAIL reset_scratch_zero got=%h required 0", v);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_after_r ar=%b rv=%b required 1/0", arready, rvalid);
    end
  endtask

  task automatic test_rw();
    logic [31:0] v;
    do_write(6'h04, 32'hDEAD_BEEF);
    do_read(6'h04, "scratch_rw", v);
    checks++;
    if (v !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL scratch_value got=%h required deadbeef", v);
    end
    status_in = 32'h0000_00A5;
    do_write(6'h08, 32'h1234_5678);
    do_read(6'h08, "status_ro", v);
    checks++;
    if (v !== 32'h0000_00A5) begin
      errors++;
      $display("FAIL status_value got=%h required 000000a5", v);
    end
    do_write(6'h07, 32'hCAFE_0001);
    do_read(6'h05, "scratch_bytelane", v);
  endtask

  task automatic test_counter();
    logic [31:0] v;
    do_write(6'h00, 32'h1);
    repeat (10) @(negedge clk);
    do_read(6'h0C, "count_run", v);
    checks++;
    if (v < 9 || v > 11) begin
      errors++;
      $display("FAIL count_range got=%0d required 9..11", v);
    end
    do_write(6'h00, 32'h3);
    do_read(6'h0C, "count_clear", v);
    checks++;
    if (v > 2) begin
      errors++;
      $display("FAIL count_small got=%0d required <=2", v);
    end
    do_read(6'h00, "ctrl_bit1_reads0", v);
    checks++;
    if (v !== 32'h1 || ctrl_out !== 32'h1) begin
      errors++;
      $display("FAIL ctrl_value got=%h ctrl_out=%h required 1", v, ctrl_out);
    end
    repeat (3) @(negedge clk);
    do_read(6'h0C, "count_again", v);
  endtask

  task automatic test_backpressure();
    exp_t e1;
    exp_t e2;
    exp_t p;
    @(negedge clk);
    status_in = 32'h0000_5A5A;
    araddr = 6'h04;
    arvalid = 1'b1;
    rready = 1'b0;
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle arready=%b required 1", arready);
    end
    e1 = model_exp(6'h04);
    q.push_back(e1);
    @(negedge clk);
    araddr = 6'h08;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || arready !== 1'b0 ||
          rdata !== e1.d || rresp !== e1.r) begin
        errors++;
        $display("FAIL bp_hold%0d rv=%b ar=%b rd=%h required 1/0/%h",
                 i, rvalid, arready, rdata, e1.d);
      end
      @(negedge clk);
    end
    rready = 1'b1;
    p = q.pop_front();
    checks++;
    if (rdata !== p.d || rresp !== p.r) begin
      errors++;
      $display("FAIL bp_first rdata=%h required %h", rdata, p.d);
    end
    @(negedge clk);
    checks++;
    if (arready !== 1'b1 || rvalid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release ar=%b rv=%b required 1/0", arready, rvalid);
    end
    e2 = model_exp(6'h08);
    q.push_back(e2);
    @(negedge clk);
    arvalid = 1'b0;
    p = q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== p.d || rresp !== p.r) begin
      errors++;
      $display("FAIL bp_second rv=%b rdata=%h required 1/%h",
               rvalid, rdata, p.d);
    end
  endtask

  task automatic test_same_edge();
    exp_t p;
    logic [31:0] v;
    do_write(6'h04, 32'hAA);
    @(negedge clk);
    wr_en = 1'b1;
    wr_addr = 6'h04;
    wr_data = 32'h55;
    araddr = 6'h04;
    arvalid = 1'b1;
    rready = 1'b1;
    q.push_back(model_exp(6'h04));
    @(negedge clk);
    wr_en = 1'b0;
    arvalid = 1'b0;
    p = q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== p.d || rdata !== 32'hAA) begin
      errors++;
      $display("FAIL same_edge rv=%b rdata=%h required 1/000000aa",
               rvalid, rdata);
    end
    do_read(6'h04, "same_edge_after", v);
    checks++;
    if (v !== 32'h55) begin
      errors++;
      $display("FAIL same_edge_new got=%h required 00000055", v);
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] v;
    logic [31:0] c0;
    do_read(6'h10, "oor_read", v);
    checks++;
    if (v !== 32'h0 || rresp !== 2'b10) begin
      errors++;
      $display("FAIL oor_resp rdata=%h rresp=%b required 0/10", v, rresp);
    end
    c0 = ctrl_out;
    do_write(6'h14, 32'hFFFF_FFFF);
    do_write(6'h10, 32'hFFFF_FFFF);
    do_read(6'h04, "oor_scratch_kept", v);
    checks++;
    if (ctrl_out !== c0) begin
      errors++;
      $display("FAIL oor_ctrl ctrl_out=%h required %h", ctrl_out, c0);
    end
    do_read(6'h30, "oor_high", v);
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] v;
    exp_t p;
    @(negedge clk);
    araddr = 6'h04;
    arvalid = 1'b1;
    rready = 1'b0;
    q.push_back(model_exp(6'h04));
    @(negedge clk);
    arvalid = 1'b0;
    checks++;
    if (rvalid !== 1'b1) begin
      errors++;
      $display("FAIL mid_rvalid got=%b required 1", rvalid);
    end
    rst = 1'b1;
    status_in = 32'h0;
    @(negedge clk);
    p = q.pop_front();
    checks++;
    if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 32'h0 ||
        rresp !== 2'b00 || ctrl_out !== 32'h0) begin
      errors++;
      $display("FAIL mid_reset rv=%b ar=%b rd=%h ctrl=%h required 0",
               rvalid, arready, rdata, ctrl_out);
    end
    rst = 1'b0;
    rready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      do_read(6'(i * 4), "post_reset_reg", v);
      checks++;
      if (v !== 32'h0) begin
        errors++;
        $display("FAIL post_reset_zero%0d got=%h required 0", i, v);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    araddr = '0;
    arvalid = 1'b0;
    rready = 1'b0;
    status_in = '0;
    test_reset();
    test_rw();
    test_counter();
    test_backpressure();
    test_same_edge();
    test_out_of_range();
    test_reset_mid_read();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_lite_reg_bank.md
# axi_lite_reg_bank

AXI-Lite register bank and read-channel slave. It sits directly downstream of the AXI-Lite write FSM and consumes that block's one-cycle `wr_en` / `wr_addr` / `wr_data` register-write strobe. It holds four 32-bit registers: control, scratch, status and a cycle counter. It also serves the AXI-Lite read-address and read-data channels with a two-state handshake FSM.

## Interface
- `ADDR_WIDTH`, 4: byte-address width of the write port and of `araddr`; must be ≥ 4.
- `DATA_WIDTH`, 32: register and data width; fixed at 32.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: one-cycle register-write strobe from the write FSM.
- `wr_addr` input ADDR_WIDTH: byte address of the write.
- `wr_data` input DATA_WIDTH: write data.
- `araddr` input ADDR_WIDTH: AXI read address.
- `arvalid` input 1: read address valid.
- `arready` output 1: read address ready.
- `rdata` output DATA_WIDTH: read data.
- `rresp` output 2: read response; 2'b00 OKAY, 2'b10 SLVERR.
- `rvalid` output 1: read data valid.
- `rready` input 1: master ready for read data.
- `status_in` input DATA_WIDTH: hardware status, sampled every cycle.
- `ctrl_out` output DATA_WIDTH: current value of REG0.

## Operation
- Decode: register index = `addr[3:2]`; `addr[1:0]` ignored. If `ADDR_WIDTH` > 4 and `addr[ADDR_WIDTH-1:4]` ≠ 0, the address is out of range.
- REG0 CTRL (RW):
  - bit0 = counter enable, stored.
  - bit1 = counter clear, self-clearing, not stored, reads 0.
  - bits[31:2] stored as written.
- REG1 SCRATCH (RW): plain 32-bit storage.
- REG2 STATUS (RO): `status_in` registered every cycle; writes ignored.
- REG3 COUNT (RO):
  - +1 per cycle while CTRL bit0 = 1; wraps 0xFFFFFFFF → 0.
  - Writes ignored.
  - A write to REG0 with bit1 = 1 clears it at that edge; clear has priority over increment.
- Writes: on `wr_en`=1, the addressed RW register updates at that edge. Writes to RO registers or out-of-range addresses are silently dropped.
- Read FSM states:
  - R_IDLE: `arready`=1. On `arvalid`=1, capture the selected register value into `rdata` and go to R_DATA.
    - In-range address: `rresp`=OKAY.
    - Out-of-range address: `rdata`=0, `rresp`=SLVERR.
  - R_DATA: `arready`=0, `rvalid`=1. `rdata`/`rresp` held stable. On `rready`=1, go to R_IDLE.
- `arready` is a decode of state == R_IDLE, forced to 0 while `rst`=1.

## Timing
- Reset (sync, `rst`=1 at an edge):
  - State → R_IDLE.
  - All registers 0, so `ctrl_out`=0 and the counter is 0.
  - `rvalid`=0, `rdata`=0, `rresp`=00, `arready`=0 while asserted.
  - Any in-flight read is dropped with no `rvalid`.
- Read latency: AR handshake at edge N → `rvalid`=1 in the cycle after N.
  - `rready` already high → R handshake at edge N+1, `arready`=1 again after N+1.
  - Maximum throughput is one read per 2 cycles.
- `rready` low: `rvalid`, `rdata` and `rresp` stay constant indefinitely; no new AR accepted.
- Write port is independent of the read FSM and always accepted (no back-pressure); zero-cycle visibility: register updates at the `wr_en` edge.
- Simultaneous write and AR handshake to the same register at edge N: `rdata` returns the pre-write value. The new value is visible to a read whose AR handshake is at edge N+1 or later.
- STATUS read returns `status_in` as sampled one edge before the AR handshake edge.
- COUNT read returns the counter value before the increment at the AR handshake edge.
- `ctrl_out` reflects REG0 bits[31:2] and bit0 from the edge after the write; bit1 is always 0.

## Test plan
- Reset, then AR to 0x4 with `rready`=1 → `rvalid` one cycle later, `rdata`=0, `rresp`=00; `arready` back to 1 after the R handshake.
- Write 0xDEADBEEF to 0x4, then read 0x4 → 0xDEADBEEF. Write 0x12345678 to 0x8 (RO), then read 0x8 with `status_in`=0x000000A5 → 0x000000A5.
- Write 0x1 to 0x0, wait 10 cycles, read 0xC → value in 9..11 matching the model exactly. Write 0x3 to 0x0 → next COUNT read is small, and CTRL reads 0x1.
- Hold `rready`=0 for 5 cycles after AR → `rvalid` stays 1, `rdata` stable, `arready`=0, and a second `arvalid` is not accepted until the R handshake.
- Same-edge write of 0x55 to 0x4 and AR to 0x4 over an old value of 0xAA → `rdata`=0xAA; the following read returns 0x55.
- With `ADDR_WIDTH`=6: read 0x10 → `rdata`=0, `rresp`=10. Write to 0x14 → no register changes. Assert `rst` during R_DATA → `rvalid`=0 at the next edge and all registers 0.
